// File: rtl/img_rsz_frm_ctrl.sv
// Frame sequencer for the resizer input: latches frame config on start,
// counts raster coordinates, gates the pixel handshake, counts resized
// output pixels and reports done / error (overflow or stall timeout).
// Ports: Clk/Reset; Cfg* frame config; FrmStart/FrmBusy/FrmDone/FrmErr
// host side; SrcVld/SrcRdy source; ImgWidth/ImgHeight/PxlX/PxlY/PxlVld/
// PxlRdy resizer input; RszObsVld/RszObsRdy snooped resizer output.
module img_rsz_frm_ctrl #(
  parameter int IMG_WIDTH_IDX_W  = 10,
  parameter int IMG_HEIGHT_IDX_W = 10,
  parameter int RSZ_CNT_W        = 16,
  parameter int TMO_W            = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [IMG_WIDTH_IDX_W-1:0]  CfgLastX,
  input  logic [IMG_HEIGHT_IDX_W-1:0] CfgLastY,
  input  logic [RSZ_CNT_W-1:0]        CfgRszCnt,
  input  logic [TMO_W-1:0]            CfgTmo,
  input  logic                        FrmStart,
  output logic                        FrmBusy,
  output logic                        FrmDone,
  output logic                        FrmErr,
  input  logic                        SrcVld,
  output logic                        SrcRdy,
  output logic [IMG_WIDTH_IDX_W-1:0]  ImgWidth,
  output logic [IMG_HEIGHT_IDX_W-1:0] ImgHeight,
  output logic [IMG_WIDTH_IDX_W-1:0]  PxlX,
  output logic [IMG_HEIGHT_IDX_W-1:0] PxlY,
  output logic                        PxlVld,
  input  logic                        PxlRdy,
  input  logic                        RszObsVld,
  input  logic                        RszObsRdy
);

  localparam logic [IMG_WIDTH_IDX_W-1:0]  X_ONE   = IMG_WIDTH_IDX_W'(1);
  localparam logic [IMG_HEIGHT_IDX_W-1:0] Y_ONE   = IMG_HEIGHT_IDX_W'(1);
  localparam logic [RSZ_CNT_W-1:0]        RSZ_ONE = RSZ_CNT_W'(1);
  localparam logic [TMO_W-1:0]            TMO_ONE = TMO_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PIX,
    DRAIN,
    DONE
  } stateT;

  stateT                 state;
  stateT                 stateNxt;
  logic [RSZ_CNT_W-1:0]  rszCnt;
  logic [RSZ_CNT_W-1:0]  rszCntNxt;
  logic [RSZ_CNT_W-1:0]  rszTgt;
  logic [TMO_W-1:0]      tmoCnt;
  logic [TMO_W-1:0]      tmoLim;
  logic                  inPix;
  logic                  active;
  logic                  startAcc;
  logic                  pxlAcc;
  logic                  rszAcc;
  logic                  ovf;
  logic                  lastPxl;
  logic                  tmoHit;
  logic                  tgtMet;

  assign inPix    = (state == PIX);
  assign active   = (state == PIX) || (state == DRAIN);
  assign startAcc = (state == IDLE) && FrmStart;
  assign PxlVld   = inPix && SrcVld;
  assign SrcRdy   = inPix && PxlRdy;
  assign pxlAcc   = PxlVld && PxlRdy;
  assign rszAcc   = active && RszObsVld && RszObsRdy;
  assign ovf      = rszAcc && (rszCnt == rszTgt);

  // Saturate so a runaway resizer cannot wrap the count below target.
  assign rszCntNxt = (rszAcc && !(&rszCnt)) ? rszCnt + RSZ_ONE : rszCnt;
  assign tgtMet    = (rszCntNxt >= rszTgt);
  assign lastPxl   = pxlAcc && (PxlX == ImgWidth) && (PxlY == ImgHeight);

  // Timeout fires on the stall cycle that would take the count to the limit.
  assign tmoHit = active && (tmoLim != '0) && !pxlAcc && !rszAcc &&
                  (tmoCnt == tmoLim - TMO_ONE);

  always_comb begin
    stateNxt = state;
    FrmBusy  = 1'b0;
    FrmDone  = 1'b0;
    unique case (state)
      IDLE: begin
        if (FrmStart) stateNxt = PIX;
      end
      PIX: begin
        FrmBusy = 1'b1;
        if (tmoHit) stateNxt = DONE;
        else if (lastPxl) stateNxt = tgtMet ? DONE : DRAIN;
      end
      DRAIN: begin
        FrmBusy = 1'b1;
        if (tmoHit || tgtMet) stateNxt = DONE;
      end
      DONE: begin
        FrmDone  = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      FrmErr    <= 1'b0;
      ImgWidth  <= '0;
      ImgHeight <= '0;
      PxlX      <= '0;
      PxlY      <= '0;
      rszTgt    <= '0;
      tmoLim    <= '0;
      rszCnt    <= '0;
      tmoCnt    <= '0;
    end else begin
      state <= stateNxt;
      if (startAcc) begin
        ImgWidth  <= CfgLastX;
        ImgHeight <= CfgLastY;
        rszTgt    <= CfgRszCnt;
        tmoLim    <= CfgTmo;
        PxlX      <= '0;
        PxlY      <= '0;
        rszCnt    <= '0;
        tmoCnt    <= '0;
        FrmErr    <= 1'b0;
      end else if (active) begin
        if (pxlAcc) begin
          if (PxlX == ImgWidth) begin
            PxlX <= '0;
            PxlY <= PxlY + Y_ONE;
          end else begin
            PxlX <= PxlX + X_ONE;
          end
        end
        rszCnt <= rszCntNxt;
        if (ovf || tmoHit) FrmErr <= 1'b1;
        if (pxlAcc || rszAcc || (tmoLim == '0)) tmoCnt <= '0;
        else tmoCnt <= tmoCnt + TMO_ONE;
      end
    end
  end

endmodule
